// File: rtl/seg_scan_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : seg_scan_scheduler
// Description : Time-multiplexed scan controller for an 8-digit common-anode
//               seven-segment display. Latches segment codes and config once
//               per frame, walks the digit selects with 16-step PWM brightness
//               and an all-off blank gap between digits.
// Options     : define SEG_SCAN_LZ_BLANK_EN to blank leading "0" digits.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seg_scan_scheduler #(
  parameter int unsigned TICK_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter logic [7:0]  ZERO_CODE    = 8'hC0
) (
  input  logic        udp_rx_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_digits_m1,
  input  logic [3:0]  cfg_bright,
  input  logic [63:0] seg_data,
  output logic [7:0]  tub,
  output logic [7:0]  dled,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned     c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned     c_GW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(BLANK_CYCLES - 1);
  localparam logic [7:0]      c_OFF        = 8'hFF;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit c_LZ_EN = 1'b1;
`else
  localparam bit c_LZ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ON   = 3'd2,
    S_OFF  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [2:0]      r_slot;
  logic [c_PW-1:0] r_presc;
  logic [3:0]      r_duty;
  logic [c_GW-1:0] r_gap;
  logic [2:0]      r_pend_dm1;
  logic [3:0]      r_pend_bright;
  logic [2:0]      r_act_dm1;
  logic [3:0]      r_act_bright;
  logic [63:0]     r_codes;
  logic [7:0]      r_blank;
  logic [7:0]      r_tub;
  logic [7:0]      r_dled;
  logic            r_frame_done;
  logic            r_busy;

  logic            w_tick;
  logic [2:0]      w_next_slot;
  logic [7:0]      w_lz_blank;
  logic            w_lz_run;

  // Slot s shows digit 7-s; ~slot equals 7-slot for a 3-bit slot index.
  function automatic logic [7:0] f_code(input logic [63:0] codes, input logic [2:0] slot);
    return codes[{~slot, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] f_tub(input logic [63:0] codes, input logic [7:0] blank,
                                       input logic [2:0] slot);
    return blank[slot] ? c_OFF : f_code(codes, slot);
  endfunction

  function automatic logic [7:0] f_dled(input logic [7:0] blank, input logic [2:0] slot);
    return blank[slot] ? c_OFF : ~(8'h01 << slot);
  endfunction

  assign w_tick      = (r_presc == c_PRESC_LAST);
  assign w_next_slot = r_slot + 3'd1;

  // Leading-zero mask for the frame about to be loaded; the last active slot is never blanked.
  always_comb begin
    w_lz_blank = '0;
    w_lz_run   = c_LZ_EN;
    for (int s = 0; s < 7; s++) begin
      if (w_lz_run && (3'(s) < r_pend_dm1) && (f_code(seg_data, 3'(s)) == ZERO_CODE))
        w_lz_blank[s] = 1'b1;
      else
        w_lz_run = 1'b0;
    end
  end

  // Pending config register, written any cycle; consumed only at LOAD.
  always_ff @(posedge udp_rx_clk or posedge reset) begin
    if (reset) begin
      r_pend_dm1    <= 3'd7;
      r_pend_bright <= 4'd15;
    end else if (cfg_we) begin
      r_pend_dm1    <= cfg_digits_m1;
      r_pend_bright <= cfg_bright;
    end
  end

  // Scan FSM with registered outputs set on the edge entering each state.
  always_ff @(posedge udp_rx_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_slot       <= 3'd0;
      r_presc      <= '0;
      r_duty       <= 4'd0;
      r_gap        <= '0;
      r_act_dm1    <= 3'd7;
      r_act_bright <= 4'd15;
      r_codes      <= {8{c_OFF}};
      r_blank      <= 8'h00;
      r_tub        <= c_OFF;
      r_dled       <= c_OFF;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_tub   <= c_OFF;
        r_dled  <= c_OFF;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_tub   <= c_OFF;
            r_dled  <= c_OFF;
          end

          S_LOAD: begin
            r_act_dm1    <= r_pend_dm1;
            r_act_bright <= r_pend_bright;
            r_codes      <= seg_data;
            r_blank      <= w_lz_blank;
            r_slot       <= 3'd0;
            r_presc      <= '0;
            r_duty       <= 4'd0;
            if (r_pend_bright == 4'd0) begin
              r_state <= S_OFF;
              r_tub   <= c_OFF;
              r_dled  <= c_OFF;
            end else begin
              r_state <= S_ON;
              r_tub   <= f_tub(seg_data, w_lz_blank, 3'd0);
              r_dled  <= f_dled(w_lz_blank, 3'd0);
            end
          end

          S_ON: begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
              r_duty <= r_duty + 4'd1;
              if (r_duty == r_act_bright - 4'd1) begin
                r_state <= S_OFF;
                r_tub   <= c_OFF;
                r_dled  <= c_OFF;
              end
            end
          end

          S_OFF: begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
              r_duty <= r_duty + 4'd1;
              if (r_duty == 4'd15) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end
            end
          end

          S_GAP: begin
            r_gap <= r_gap + c_GW'(1);
            if (r_gap == c_GAP_LAST) begin
              if (r_slot == r_act_dm1) begin
                r_frame_done <= 1'b1;
                r_state      <= S_LOAD;
                r_tub        <= c_OFF;
                r_dled       <= c_OFF;
              end else begin
                r_slot  <= w_next_slot;
                r_presc <= '0;
                r_duty  <= 4'd0;
                if (r_act_bright == 4'd0) begin
                  r_state <= S_OFF;
                  r_tub   <= c_OFF;
                  r_dled  <= c_OFF;
                end else begin
                  r_state <= S_ON;
                  r_tub   <= f_tub(r_codes, r_blank, w_next_slot);
                  r_dled  <= f_dled(r_blank, w_next_slot);
                end
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_tub   <= c_OFF;
            r_dled  <= c_OFF;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tub        = r_tub;
  assign dled       = r_dled;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_seg_scan_scheduler
// Description : Scoreboard bench for seg_scan_scheduler. A frame-position
//               reference model queues the expected outputs of every cycle and
//               a monitor compares them against the DUT on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seg_scan_scheduler;

  localparam int TD = 4;
  localparam int BC = 2;
  localparam int SL = 16 * TD + BC;
  localparam logic [7:0] ZC = 8'hC0;

  logic        udp_rx_clk    = 1'b0;
  logic        reset         = 1'b1;
  logic        enable        = 1'b0;
  logic        cfg_we        = 1'b0;
  logic [2:0]  cfg_digits_m1 = 3'd0;
  logic [3:0]  cfg_bright    = 4'd0;
  logic [63:0] seg_data      = 64'h0;
  logic [7:0]  tub;
  logic [7:0]  dled;
  logic        frame_done;
  logic        busy;

  typedef struct packed {
    logic [7:0] tub;
    logic [7:0] dled;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  seg_scan_scheduler #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC),
    .ZERO_CODE    (ZC)
  ) dut (
    .udp_rx_clk    (udp_rx_clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_we        (cfg_we),
    .cfg_digits_m1 (cfg_digits_m1),
    .cfg_bright    (cfg_bright),
    .seg_data      (seg_data),
    .tub           (tub),
    .dled          (dled),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 udp_rx_clk = ~udp_rx_clk;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got tub=%h dled=%h frame_done=%b busy=%b, expected tub=%h dled=%h frame_done=%b busy=%b",
                  name, $time, act.tub, act.dled, act.fd, act.busy, exp.tub, exp.dled, exp.fd, exp.busy);
  endtask

  // Reference model: position within the frame decides everything.
  bit         m_run;
  int         m_pos;
  int         m_pdm1, m_pbr, m_adm1, m_abr;
  int         old_pdm1, old_pbr;
  int         m_k, m_r;
  logic [7:0] m_code [8];
  bit         m_blank [8];
  logic [7:0] one8;
  exp_t       m_e;

  always @(posedge udp_rx_clk) begin
    m_e = exp_t'({8'hFF, 8'hFF, 1'b0, 1'b0});
    if (reset) begin
      m_run = 0; m_pdm1 = 7; m_pbr = 15; m_adm1 = 7; m_abr = 15;
      for (int d = 0; d < 8; d++) begin m_code[d] = 8'hFF; m_blank[d] = 0; end
    end else begin
      old_pdm1 = m_pdm1; old_pbr = m_pbr;
      if (cfg_we) begin m_pdm1 = int'(cfg_digits_m1); m_pbr = int'(cfg_bright); end
      if (!enable) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_e.busy = 1'b1;
      end else begin
        m_pos++;
        m_e.busy = 1'b1;
        if (m_pos == 1) begin
          m_adm1 = old_pdm1; m_abr = old_pbr;
          for (int d = 0; d < 8; d++) begin m_code[d] = seg_data[d*8 +: 8]; m_blank[d] = 0; end
`ifdef SEG_SCAN_LZ_BLANK_EN
          for (int s = 0; s < m_adm1; s++) begin
            if (m_code[7-s] == ZC) m_blank[s] = 1;
            else break;
          end
`endif
        end
        if (m_pos == 1 + (m_adm1 + 1) * SL) begin
          m_pos = 0; m_e.fd = 1'b1;
        end else begin
          m_k = (m_pos - 1) / SL;
          m_r = (m_pos - 1) % SL;
          if (m_r < m_abr * TD && !m_blank[m_k]) begin
            one8 = 8'h01;
            m_e.tub  = m_code[7-m_k];
            m_e.dled = ~(one8 << m_k);
          end
        end
      end
    end
    exp_q.push_back(m_e);
  end

  // Monitor: compare one queued expectation per cycle, away from the active edge.
  exp_t mon_e, mon_a;
  always @(negedge udp_rx_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = exp_t'({tub, dled, frame_done, busy});
      check("cycle_outputs", mon_a, mon_e);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge udp_rx_clk);
  endtask

  task automatic cfg_pulse(input logic [2:0] dm1, input logic [3:0] br);
    cfg_we = 1'b1; cfg_digits_m1 = dm1; cfg_bright = br;
    @(negedge udp_rx_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    @(negedge udp_rx_clk);
    while (frame_done !== 1'b1 && n < budget) begin @(negedge udp_rx_clk); n++; end
    n_checks++;
    if (frame_done === 1'b1) n_pass++;
    else $display("FAIL wait_frame_done: no pulse within %0d cycles", budget);
  endtask

  task automatic wait_dled(input logic [7:0] val, input int budget);
    int n = 0;
    while (dled !== val && n < budget) begin @(negedge udp_rx_clk); n++; end
    n_checks++;
    if (dled === val) n_pass++;
    else $display("FAIL wait_dled: dled=%h never reached %h within %0d cycles", dled, val, budget);
  endtask

  initial begin
    run(3);
    reset = 1'b0; enable = 1'b1; seg_data = 64'hF9A4B09992828280;
    run(2 * 529 + 10);

    // Mid-frame config change: current frame unaffected, next frame 3 slots at bright 4.
    run($urandom_range(50, 400));
    cfg_pulse(3'd2, 4'd4);
    run(529 + 3 * 199);

    // Config write in the LOAD cycle itself takes effect one frame later.
    wait_fd(600);
    cfg_pulse(3'd7, 4'd0);
    run(199 + 2 * 529 + 20);

    // Segment data changes mid-frame; shows only after the next LOAD.
    cfg_pulse(3'd7, 4'd15);
    wait_fd(1200);
    run(3 * SL + 10);
    seg_data = 64'h0123456789ABCDEF;
    run(2 * 529);

    // Enable dropped during ON of slot 5, then re-enabled.
    wait_dled(8'hDF, 1200);
    enable = 1'b0;
    run(4);
    enable = 1'b1;
    run(300);

    // Randomized config, data and enable activity.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_pulse(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      seg_data = {$urandom, $urandom};
      run($urandom_range(100, 700));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 20));
        enable = 1'b1;
      end
    end

    // Leading-zero patterns on a 4-digit display.
    cfg_pulse(3'd3, 4'd15);
    seg_data = 64'hC0C0F9C0_12345678;
    run(2 * (1 + 4 * SL) + 300);
    seg_data = 64'hC0C0C0C0_00000000;
    run(2 * (1 + 4 * SL) + 50);

    // Asynchronous reset while a digit is lit.
    wait_dled(8'hFD, 600);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", exp_t'({tub, dled, frame_done, busy}), exp_t'({8'hFF, 8'hFF, 1'b0, 1'b0}));
    run(3);
    reset = 1'b0;
    run(600);

    run(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
